// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM, instruction/ALU decode, conditional execution and NZCV flags.
// Optional CMP support is compiled in with `define CTRL_CMP_EN.
module multicycle_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_ex_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  logic       next_pc, branch, reg_w, mem_w, alu_op, is_cmp, cond_ex, pcs;
  logic [1:0] flag_w;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

`ifdef CTRL_CMP_EN
  assign is_cmp = (op == 2'b00) && (funct[4:1] == 4'b1010);
`else
  assign is_cmp = 1'b0;
`endif

  // Main FSM: next state and raw (ungated) control strobes.
  always_comb begin
    state_d   = FETCH;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = ~is_cmp;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // ALU decode and flag-write enables.
  always_comb begin
    ALUControl = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = is_cmp ? 2'b01 : 2'b00;
      endcase
    end
    flag_w[1] = alu_op & funct[0];
    flag_w[0] = flag_w[1] & ~ALUControl[1];
  end

  // Condition check against the registered N,Z,C,V.
  always_comb begin
    case (cond)
      4'h0:    cond_ex = flags_q[2];
      4'h1:    cond_ex = ~flags_q[2];
      4'h2:    cond_ex = flags_q[1];
      4'h3:    cond_ex = ~flags_q[1];
      4'h4:    cond_ex = flags_q[3];
      4'h5:    cond_ex = ~flags_q[3];
      4'h6:    cond_ex = flags_q[0];
      4'h7:    cond_ex = ~flags_q[0];
      4'h8:    cond_ex = flags_q[1] & ~flags_q[2];
      4'h9:    cond_ex = ~flags_q[1] | flags_q[2];
      4'hA:    cond_ex = (flags_q[3] == flags_q[0]);
      4'hB:    cond_ex = (flags_q[3] != flags_q[0]);
      4'hC:    cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD:    cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_ex_q <= cond_ex;
      if (flag_w[1] & cond_ex) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign pcs    = ((rd == 4'hF) & reg_w) | branch;
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  // Architectural writes are suppressed for the whole reset cycle, whatever state it interrupts.
  assign RegWrite = reg_w & cond_ex_q & ~reset;
  assign MemWrite = mem_w & cond_ex_q & ~reset;
  assign PCWrite  = ((pcs & cond_ex_q) | next_pc) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model queues the expected
// per-cycle control vectors and a negedge monitor compares them against the DUT outputs.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr_in;
  logic [3:0]  alu_flags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(instr_in), .ALUFlags(alu_flags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm, aluc;
  } ctl_t;

  typedef struct {
    logic [16:0] exp;
    logic [16:0] mask;
    string       tag;
  } item_t;

  localparam logic [16:0] WR_MASK = 17'h1C000;

  item_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mflags;  // architectural NZCV as the model sees it
  logic [16:0] act;

  assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, ALUControl};

  always @(negedge clk) begin
    item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      if (((act ^ it.exp) & it.mask) != 17'h0) begin
        errors++;
        $display("FAIL %s: actual %h required %h (mask %h)", it.tag, act, it.exp, it.mask);
      end
    end
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_cmp_cmd(input logic [3:0] cmd);
`ifdef CTRL_CMP_EN
    return cmd == 4'b1010;
`else
    return (cmd == 4'b1010) && 1'b0;
`endif
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return is_cmp_cmd(cmd) ? 2'd1 : 2'd0;
    endcase
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      sb.push_back('{17'h0, WR_MASK, "reset-writes"});
      @(posedge clk); #1;
    end
    reset  = 1'b0;
    mflags = 4'h0;
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset in place of that cycle.
  task automatic run_instr(input logic [31:0] ins, input bit fix_f, input logic [3:0] ff,
                           input int abort_at);
    ctl_t       seq[$];
    string      tags[$];
    ctl_t       b, v;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] af;
    bit         c, to_pc, cmp;
    int         exec_idx;
    op       = ins[27:26];
    funct    = ins[25:20];
    c        = cond_ok(ins[31:28], mflags);
    to_pc    = (ins[15:12] == 4'hF);
    cmp      = (op == 2'b00) && is_cmp_cmd(funct[4:1]);
    exec_idx = -1;
    b        = '0;
    b.imm    = op;
    b.regsrc = {op == 2'b01, op == 2'b10};

    v = b; v.pcw = 1; v.irw = 1; v.srca = 2'b01; v.srcb = 2'b10; v.res = 2'b10;
    seq.push_back(v); tags.push_back("fetch");
    v = b; v.srca = 2'b01; v.srcb = 2'b10; v.res = 2'b10;
    seq.push_back(v); tags.push_back("decode");
    case (op)
      2'b01: begin
        v = b; v.srcb = 2'b01;
        seq.push_back(v); tags.push_back("memadr");
        if (funct[0]) begin
          v = b; v.adr = 1;
          seq.push_back(v); tags.push_back("memrd");
          v = b; v.res = 2'b01; v.regw = c; v.pcw = c && to_pc;
          seq.push_back(v); tags.push_back("memwb");
        end else begin
          v = b; v.adr = 1; v.memw = c;
          seq.push_back(v); tags.push_back("memwr");
        end
      end
      2'b00: begin
        v = b; v.srcb = funct[5] ? 2'b01 : 2'b00; v.aluc = alu_of(funct[4:1]);
        exec_idx = 2;
        seq.push_back(v); tags.push_back("execute");
        v = b; v.regw = c && !cmp; v.pcw = c && to_pc && !cmp;
        seq.push_back(v); tags.push_back("aluwb");
      end
      2'b10: begin
        v = b; v.srca = 2'b10; v.srcb = 2'b01; v.res = 2'b10; v.pcw = c;
        seq.push_back(v); tags.push_back("branch");
      end
      default: ;
    endcase

    instr_in = ins[31:12];
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        do_reset(2);
        return;
      end
      af        = fix_f ? ff : 4'($urandom);
      alu_flags = af;
      sb.push_back('{seq[i], '1, $sformatf("%s %h", tags[i], ins)});
      if (i == exec_idx && funct[0] && c) begin
        mflags[3:2] = af[3:2];
        if (alu_of(funct[4:1]) <= 2'd1) mflags[1:0] = af[1:0];
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0]  cond, rd, cmd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [31:0] r;
    logic [3:0]  cmds[6];
    cmds  = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
    cond  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE;
    op    = 2'($urandom);
    funct = 6'($urandom);
    if (op == 2'b00) begin
      cmd        = cmds[$urandom_range(0, 5)];
      funct[4:1] = cmd;
    end
    rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    r  = {cond, op, funct, 4'($urandom), rd, 12'($urandom)};
    return r;
  endfunction

  initial begin
    int budget;
    reset     = 1'b1;
    instr_in  = '0;
    alu_flags = '0;
    mflags    = 4'h0;
    @(posedge clk); #1;
    do_reset(2);

    run_instr(32'hE2802005, 0, 4'h0, -1);   // ADD R2,R0,#5
    run_instr(32'hE0503000, 1, 4'h4, -1);   // SUBS -> Z set
    run_instr(32'h0A000002, 0, 4'h0, -1);   // BEQ taken
    run_instr(32'hE0503000, 1, 4'h4, -1);
    run_instr(32'h1A000002, 0, 4'h0, -1);   // BNE not taken
    run_instr(32'hE5901004, 0, 4'h0, -1);   // LDR
    run_instr(32'hE5801004, 0, 4'h0, -1);   // STR
    run_instr(32'hE0503000, 1, 4'h4, -1);
    run_instr(32'hE5901004, 0, 4'h0, 3);    // reset during MEMRD
    run_instr(32'h0A000002, 0, 4'h0, -1);   // flags cleared: BEQ not taken
    run_instr(32'h1A000002, 0, 4'h0, -1);   // BNE taken
    run_instr(32'hE3500000, 1, 4'h4, -1);   // CMP R0,#0
    run_instr(32'h0A000002, 0, 4'h0, -1);
    run_instr(32'hE5900004, 0, 4'h0, 4);    // reset during MEMWB

    for (int n = 0; n < 400; n++) begin
      run_instr(rand_instr(), 0, 4'h0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1);
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
